// File: rtl/storage_pipeline_bank.sv
// Parametrised WIDTH x DEPTH register pipeline with per-stage valid tags,
// occupancy count and hold / shift / fill / clear modes.
module storage_pipeline_bank #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] D,
   input  logic             D_valid,
   output logic [WIDTH-1:0] Q,
   output logic             Q_valid,
   output logic [WIDTH-1:0] Q_first,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             changed
);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_SHIFT = 2'b01,
      MODE_FILL  = 2'b10,
      MODE_CLEAR = 2'b11
   } mode_t;

   logic signed [WIDTH-1:0] stage [DEPTH];
   logic [DEPTH-1:0]        vld;
   logic [CNT_W-1:0]        cnt;
   logic                    chg;

   // Occupancy update clamped to 0..DEPTH so a malformed tag history can never wrap.
   function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c,
                                                   input logic add,
                                                   input logic sub);
      logic [CNT_W:0] t;
      t = {1'b0, c} + {{CNT_W{1'b0}}, add};
      if (t < {{CNT_W{1'b0}}, sub}) return '0;
      t = t - {{CNT_W{1'b0}}, sub};
      if (t > (CNT_W + 1)'(DEPTH)) return CNT_W'(DEPTH);
      return t[CNT_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
         vld <= '0;
         cnt <= '0;
         chg <= 1'b0;
      end else begin
         case (mode_t'(mode))
            MODE_HOLD: begin
               chg <= 1'b0;
            end
            MODE_SHIFT: begin
               stage[0] <= D;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
               vld <= {vld[DEPTH-2:0], D_valid};
               cnt <= sat_count(cnt, D_valid, vld[DEPTH-1]);
               chg <= (stage[DEPTH-2] != stage[DEPTH-1]);
            end
            MODE_FILL: begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= D;
               vld <= '1;
               cnt <= CNT_W'(DEPTH);
               chg <= (D != stage[DEPTH-1]);
            end
            MODE_CLEAR: begin
               // Data is left in place; only the tags and count are dropped.
               vld <= '0;
               cnt <= '0;
               chg <= 1'b0;
            end
            default: chg <= 1'b0;
         endcase
      end
   end

   assign Q       = stage[DEPTH-1];
   assign Q_valid = vld[DEPTH-1];
   assign Q_first = stage[0];
   assign count   = cnt;
   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign changed = chg;

endmodule
